uart_hex_fmt: RTL and testbench

Upstream formatter for the `uart` transmit wrapper. It accepts a binary word on a valid/ready port and emits its uppercase hexadecimal ASCII text, most significant nibble first, followed by CR LF. Bytes go out one at a time over the wrapper's `tx_byte`/`tx_en`/`tx_ready` handshake. Typical use is debug dumps of registers or counters to the serial pin.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_hex_fmt_if.sv | 22 ++
 rtl/uart_byte_push.sv | 58 +++++
 rtl/uart_hex_fmt.sv | 116 +++++++++++
 tb/tb_uart_hex_fmt.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - ASCII constants, state types and nibble-to-hex encoding for uart_hex_fmt
package uart_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_X  = 8'h78;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_P0,
        SEQ_P1,
        SEQ_DIG,
        SEQ_CR,
        SEQ_LF
    } seq_state_t;

    typedef enum logic {
        PUSH_ARM,
        PUSH_ACK
    } push_state_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_hex_fmt_if.sv
// rtl/uart_hex_fmt_if.sv - word input and UART byte handshake bundle for uart_hex_fmt
interface uart_hex_fmt_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] val_data;
    logic              val_valid;
    logic              val_ready;
    logic [7:0]        tx_byte;
    logic              tx_en;
    logic              tx_ready;
    logic              busy;

    modport master (
        input  val_data, val_valid, tx_ready,
        output val_ready, tx_byte, tx_en, busy
    );

    modport slave (
        output val_data, val_valid, tx_ready,
        input  val_ready, tx_byte, tx_en, busy
    );
endinterface

// File: rtl/uart_byte_push.sv
// rtl/uart_byte_push.sv - ARM/ACK request handshake pushing one byte at a time to the UART wrapper
module uart_byte_push (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       push,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_en,
    output logic       done,
    output logic       idle
);
    import uart_pkg::*;

    push_state_t st, st_n;
    logic [7:0]  tx_byte_n;
    logic        tx_en_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= PUSH_ARM;
            tx_byte <= 8'h00;
            tx_en   <= 1'b0;
        end else begin
            st      <= st_n;
            tx_byte <= tx_byte_n;
            tx_en   <= tx_en_n;
        end
    end

    // done is combinational so the sequencer advances on the same edge tx_en falls
    always_comb begin
        st_n      = st;
        tx_byte_n = tx_byte;
        tx_en_n   = tx_en;
        done      = 1'b0;
        case (st)
            PUSH_ARM: begin
                if (push && tx_ready) begin
                    st_n      = PUSH_ACK;
                    tx_byte_n = byte_in;
                    tx_en_n   = 1'b1;
                end
            end
            PUSH_ACK: begin
                if (!tx_ready) begin
                    st_n    = PUSH_ARM;
                    tx_en_n = 1'b0;
                    done    = 1'b1;
                end
            end
            default: st_n = PUSH_ARM;
        endcase
    end

    assign idle = (st == PUSH_ARM);

endmodule

// File: rtl/uart_hex_fmt.sv
// rtl/uart_hex_fmt.sv - prints a word as uppercase hex + CR LF over the UART byte handshake; UART_HEX_FMT_PREFIX_EN adds "0x"
module uart_hex_fmt #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    uart_hex_fmt_if.master bus
);
    import uart_pkg::*;

    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    seq_state_t        state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              rdy_q;
    logic [7:0]        byte_cur;
    logic              push;
    logic              done;
    logic              push_idle;
    logic              accept;
    logic [7:0]        tx_byte_w;
    logic              tx_en_w;

    assign accept = bus.val_valid && rdy_q && push_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_IDLE;
            shreg <= '0;
            cnt   <= '0;
            rdy_q <= 1'b1;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
            rdy_q <= (state_n == SEQ_IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        byte_cur = 8'h00;
        push     = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (accept) begin
                    shreg_n = bus.val_data;
                    cnt_n   = CNT_W'(NIB - 1);
`ifdef UART_HEX_FMT_PREFIX_EN
                    state_n = SEQ_P0;
`else
                    state_n = SEQ_DIG;
`endif
                end
            end
`ifdef UART_HEX_FMT_PREFIX_EN
            SEQ_P0: begin
                push     = 1'b1;
                byte_cur = ASCII_0;
                if (done) state_n = SEQ_P1;
            end
            SEQ_P1: begin
                push     = 1'b1;
                byte_cur = ASCII_X;
                if (done) state_n = SEQ_DIG;
            end
`endif
            SEQ_DIG: begin
                push     = 1'b1;
                byte_cur = hex2ascii(shreg[DATA_W-1 -: 4]);
                if (done) begin
                    shreg_n = shreg << 4;
                    // counter parks at 0 once the last digit is out
                    if (cnt == '0) begin
                        state_n = SEQ_CR;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            SEQ_CR: begin
                push     = 1'b1;
                byte_cur = ASCII_CR;
                if (done) state_n = SEQ_LF;
            end
            SEQ_LF: begin
                push     = 1'b1;
                byte_cur = ASCII_LF;
                if (done) state_n = SEQ_IDLE;
            end
            default: state_n = SEQ_IDLE;
        endcase
    end

    uart_byte_push u_push (
        .clk      (clk),
        .rst      (rst),
        .byte_in  (byte_cur),
        .push     (push),
        .tx_ready (bus.tx_ready),
        .tx_byte  (tx_byte_w),
        .tx_en    (tx_en_w),
        .done     (done),
        .idle     (push_idle)
    );

    assign bus.tx_byte   = tx_byte_w;
    assign bus.tx_en     = tx_en_w;
    assign bus.val_ready = rdy_q;
    assign bus.busy      = ~rdy_q;

endmodule

// File: tb/tb_uart_hex_fmt.sv
// tb/tb_uart_hex_fmt.sv - directed bench for uart_hex_fmt with a UART wrapper model
`timescale 1ns/1ps
module tb_uart_hex_fmt;

`ifdef UART_HEX_FMT_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif

    logic clk;
    logic rst;
    logic tx_ready;
    logic sel8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_hex_fmt_if #(.DATA_W(32)) bus32 ();
    uart_hex_fmt_if #(.DATA_W(8))  bus8 ();

    uart_hex_fmt #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    uart_hex_fmt #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    assign bus32.tx_ready = tx_ready;
    assign bus8.tx_ready  = tx_ready;

    wire       tx_en_m   = sel8 ? bus8.tx_en   : bus32.tx_en;
    wire [7:0] tx_byte_m = sel8 ? bus8.tx_byte : bus32.tx_byte;
    wire       rdy_m     = sel8 ? bus8.val_ready : bus32.val_ready;

    int vectors     = 0;
    int miscompares = 0;
    int pre_hold    = 0;
    int stall_idx   = -1;
    int arm_viol    = 0;
    int stab_err    = 0;
    int m_st        = 0;
    int m_cnt       = 0;
    logic [7:0] cur;
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] g;
    bit         to;

    // Wrapper model: drops tx_ready 2 cycles after a request, restores it 3 cycles later
    initial begin : wrapper_model
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_st = 0;
                tx_ready = 1'b1;
            end else if (pre_hold > 0) begin
                if (tx_en_m) arm_viol++;
                pre_hold--;
                tx_ready = (pre_hold == 0);
            end else begin
                case (m_st)
                    0: if (tx_en_m) begin
                        cur = tx_byte_m;
                        got.push_back(cur);
                        m_cnt = (got.size() - 1 == stall_idx) ? 16 : 1;
                        m_st = 1;
                    end
                    1: begin
                        if (!tx_en_m || tx_byte_m !== cur) stab_err++;
                        if (m_cnt == 0) begin
                            tx_ready = 1'b0;
                            m_cnt = 2;
                            m_st = 2;
                        end else m_cnt--;
                    end
                    default: begin
                        if (m_cnt == 0) begin
                            tx_ready = 1'b1;
                            m_st = 0;
                        end else m_cnt--;
                    end
                endcase
            end
        end
    end

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        if (sel8) begin bus8.val_data = w[7:0]; bus8.val_valid = 1'b1; end
        else      begin bus32.val_data = w;     bus32.val_valid = 1'b1; end
        @(posedge clk); #1;
        bus8.val_valid  = 1'b0;
        bus32.val_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rdy_m) begin timed_out = 1'b0; break; end
        end
        if (timed_out) begin
            vectors++; miscompares++;
            $display("FAIL wait_ready: val_ready still %b after %0d cycles, required 1", rdy_m, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel8 = 1'b0;
        bus32.val_valid = 1'b0; bus32.val_data = '0;
        bus8.val_valid  = 1'b0; bus8.val_data  = '0;
        repeat (3) @(negedge clk);
        vectors++; if (bus32.val_ready !== 1'b1) begin miscompares++; $display("FAIL rst_val_ready: got %b want 1", bus32.val_ready); end
        vectors++; if (bus32.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus32.busy); end
        vectors++; if (bus32.tx_en !== 1'b0) begin miscompares++; $display("FAIL rst_tx_en: got %b want 0", bus32.tx_en); end
        vectors++; if (bus32.tx_byte !== 8'h00) begin miscompares++; $display("FAIL rst_tx_byte: got %h want 00", bus32.tx_byte); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_deadbeef();
        got.delete();
        exp = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
`ifdef UART_HEX_FMT_PREFIX_EN
        exp.push_front(8'h78); exp.push_front(8'h30);
`endif
        send(32'hDEADBEEF);
        vectors++; if (bus32.val_ready !== 1'b0) begin miscompares++; $display("FAIL deadbeef_ready_low: got %b want 0", bus32.val_ready); end
        wait_ready(400, to);
        vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL deadbeef_count: got %0d want %0d at val_ready rise", got.size(), exp.size()); end
        vectors++; if (bus32.busy !== 1'b0) begin miscompares++; $display("FAIL deadbeef_busy: got %b want 0", bus32.busy); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL deadbeef_byte%0d: got %h want %h", i, g, exp[i]); end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_stall();
        got.delete(); arm_viol = 0; stab_err = 0;
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
`ifdef UART_HEX_FMT_PREFIX_EN
        exp.push_front(8'h78); exp.push_front(8'h30);
`endif
        stall_idx = 3;
        @(negedge clk);
        pre_hold = 21;
        send(32'h12345678);
        wait_ready(600, to);
        stall_idx = -1;
        vectors++; if (arm_viol !== 0) begin miscompares++; $display("FAIL stall_arm: tx_en seen high %0d times while tx_ready low, want 0", arm_viol); end
        vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL stall_stable: %0d unstable ACK cycles, want 0", stab_err); end
        vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL stall_byte%0d: got %h want %h", i, g, exp[i]); end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        got.delete();
        exp = {};
        for (int m = 0; m < 2; m++) begin
`ifdef UART_HEX_FMT_PREFIX_EN
            exp.push_back(8'h30); exp.push_back(8'h78);
`endif
            for (int d = 0; d < 8; d++) exp.push_back(m == 0 ? 8'h30 : 8'h46);
            exp.push_back(8'h0D); exp.push_back(8'h0A);
        end
        @(negedge clk);
        bus32.val_data = 32'h00000000; bus32.val_valid = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus32.val_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_first_accept: val_ready %b want 0", bus32.val_ready); end
        bus32.val_data = 32'hFFFFFFFF;
        wait_ready(400, to);
        vectors++; if (got.size() !== exp.size() / 2) begin miscompares++; $display("FAIL b2b_first_len: got %0d want %0d", got.size(), exp.size() / 2); end
        @(posedge clk); #1;
        vectors++; if (bus32.val_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_second_accept: val_ready %b want 0 after rise cycle", bus32.val_ready); end
        bus32.val_valid = 1'b0;
        wait_ready(400, to);
        repeat (25) @(negedge clk);
        vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL b2b_byte%0d: got %h want %h", i, g, exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        got.delete();
        send(32'hCAFEF00D);
        to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (got.size() == PFX + 3) begin to = 1'b0; break; end
        end
        if (to) begin vectors++; miscompares++; $display("FAIL rstmid_wait: %0d bytes seen, want %0d", got.size(), PFX + 3); end
        rst = 1'b1;
        #1;
        vectors++; if (bus32.tx_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_tx_en: got %b want 0", bus32.tx_en); end
        vectors++; if (bus32.tx_byte !== 8'h00) begin miscompares++; $display("FAIL rstmid_tx_byte: got %h want 00", bus32.tx_byte); end
        vectors++; if (bus32.val_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_val_ready: got %b want 1", bus32.val_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got.delete();
        exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
`ifdef UART_HEX_FMT_PREFIX_EN
        exp.push_front(8'h78); exp.push_front(8'h30);
`endif
        send(32'h0123ABCD);
        wait_ready(400, to);
        vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d want %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL rstmid_byte%0d: got %h want %h", i, g, exp[i]); end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_narrow();
        sel8 = 1'b1;
        for (int v = 0; v < 2; v++) begin
            got.delete();
            exp = (v == 0) ? '{8'h30, 8'h39, 8'h0D, 8'h0A} : '{8'h46, 8'h30, 8'h0D, 8'h0A};
`ifdef UART_HEX_FMT_PREFIX_EN
            exp.push_front(8'h78); exp.push_front(8'h30);
`endif
            send(v == 0 ? 32'h09 : 32'hF0);
            wait_ready(200, to);
            vectors++; if (got.size() !== exp.size()) begin miscompares++; $display("FAIL narrow%0d_count: got %0d want %0d", v, got.size(), exp.size()); end
            for (int i = 0; i < exp.size(); i++) begin
                g = (i < got.size()) ? got[i] : 8'hxx;
                vectors++; if (g !== exp[i]) begin miscompares++; $display("FAIL narrow%0d_byte%0d: got %h want %h", v, i, g, exp[i]); end
            end
            repeat (8) @(negedge clk);
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
